// File: rtl/fb_ddr_pkg.sv
// -----------------------------------------------------------------------------
// fb_ddr_pkg
// Shared definitions for the rotated-framebuffer DDRAM arbiter:
//   - DDRAM address / data / byte-enable widths
//   - packed write-entry layout held in the posted-write FIFO (29+64+8 = 101)
//   - arbiter FSM state encodings
//   - burst_len(): maps a requested burst length of 0 onto 1
// -----------------------------------------------------------------------------
package fb_ddr_pkg;

  localparam int DDR_AW  = 29;
  localparam int DDR_DW  = 64;
  localparam int DDR_BEW = 8;
  localparam int WENT_W  = DDR_AW + DDR_DW + DDR_BEW;

  localparam logic [1:0] ENC_IDLE    = 2'd0;
  localparam logic [1:0] ENC_WR      = 2'd1;
  localparam logic [1:0] ENC_RD_CMD  = 2'd2;
  localparam logic [1:0] ENC_RD_DATA = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = ENC_IDLE,
    ST_WR      = ENC_WR,
    ST_RD_CMD  = ENC_RD_CMD,
    ST_RD_DATA = ENC_RD_DATA
  } state_t;

  typedef struct packed {
    logic [DDR_AW-1:0]  addr;
    logic [DDR_DW-1:0]  din;
    logic [DDR_BEW-1:0] be;
  } wr_entry_t;

  function automatic logic [7:0] burst_len(input logic [7:0] len);
    return (len == 8'd0) ? 8'd1 : len;
  endfunction

endpackage

// File: rtl/fb_ddr_arb_if.sv
// -----------------------------------------------------------------------------
// fb_ddr_arb_if
// Bundles the arbiter's requester-side and DDRAM-side signals.
//   slave  : view used by fb_ddr_arb
//   master : view used by the surrounding logic (rotator, core, DDRAM pins)
// Signals:
//   wr_req/wr_addr/wr_din/wr_be, wr_ovf       posted rotator writes
//   rd_req/rd_addr/rd_len, rd_ack/rd_dout/
//   rd_dv/rd_done                             core burst reads
//   DDRAM_*                                   Avalon-style DDRAM port
// -----------------------------------------------------------------------------
interface fb_ddr_arb_if;
  import fb_ddr_pkg::*;

  logic               wr_req;
  logic [DDR_AW-1:0]  wr_addr;
  logic [DDR_DW-1:0]  wr_din;
  logic [DDR_BEW-1:0] wr_be;
  logic               wr_ovf;

  logic               rd_req;
  logic [DDR_AW-1:0]  rd_addr;
  logic [7:0]         rd_len;
  logic               rd_ack;
  logic [DDR_DW-1:0]  rd_dout;
  logic               rd_dv;
  logic               rd_done;

  logic               DDRAM_BUSY;
  logic [7:0]         DDRAM_BURSTCNT;
  logic [DDR_AW-1:0]  DDRAM_ADDR;
  logic [DDR_DW-1:0]  DDRAM_DIN;
  logic [DDR_BEW-1:0] DDRAM_BE;
  logic               DDRAM_WE;
  logic               DDRAM_RD;
  logic [DDR_DW-1:0]  DDRAM_DOUT;
  logic               DDRAM_DOUT_READY;

  modport slave (
    input  wr_req, wr_addr, wr_din, wr_be,
    output wr_ovf,
    input  rd_req, rd_addr, rd_len,
    output rd_ack, rd_dout, rd_dv, rd_done,
    input  DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
    output DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_DIN, DDRAM_BE, DDRAM_WE, DDRAM_RD
  );

  modport master (
    output wr_req, wr_addr, wr_din, wr_be,
    input  wr_ovf,
    output rd_req, rd_addr, rd_len,
    input  rd_ack, rd_dout, rd_dv, rd_done,
    output DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
    input  DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_DIN, DDRAM_BE, DDRAM_WE, DDRAM_RD
  );

endinterface

// File: rtl/fb_ddr_wfifo.sv
// -----------------------------------------------------------------------------
// fb_ddr_wfifo
// Synchronous FIFO for posted rotator writes. A push is admitted only when the
// FIFO is not full at the start of the cycle; a pop in the same cycle does not
// make room for it.
// Ports:
//   clk_video, rst      clock, synchronous active-high reset
//   i_push_req          push request (one entry)
//   i_push_data         entry to store
//   i_pop               remove the head entry
//   o_head              current head entry (valid when !o_empty)
//   o_level             occupancy, 0..2^AW
//   o_empty             level == 0
//   o_drop              push requested while full (entry discarded)
// -----------------------------------------------------------------------------
module fb_ddr_wfifo
  import fb_ddr_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic        clk_video,
  input  logic        rst,
  input  logic        i_push_req,
  input  wr_entry_t   i_push_data,
  input  logic        i_pop,
  output wr_entry_t   o_head,
  output logic [AW:0] o_level,
  output logic        o_empty,
  output logic        o_drop
);

  localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

  logic [WENT_W-1:0] r_mem [2**AW];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_level;
  logic              w_full;
  logic              w_push;
  logic              w_pop;

  assign w_full  = (r_level == DEPTH);
  assign o_empty = (r_level == '0);
  assign w_push  = i_push_req & ~w_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_drop  = i_push_req & w_full;
  assign o_level = r_level;
  assign o_head  = wr_entry_t'(r_mem[r_rd_ptr]);

  // NOTE: the storage array is deliberately left out of reset; pointers and
  // level define which entries are valid, and an unreset array maps to RAM.
  always_ff @(posedge clk_video) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_video) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/fb_ddr_arb.sv
// -----------------------------------------------------------------------------
// fb_ddr_arb
// Shares one DDRAM port between the rotator's posted single-word writes
// (buffered in fb_ddr_wfifo) and a core-side burst reader. Reads win unless
// the write FIFO has reached HIWAT. All outputs are registered.
// Parameters: FIFO_AW (FIFO depth 2^FIFO_AW), HIWAT (write-priority level).
// Ports:
//   clk_video, rst      clock, synchronous active-high reset
//   bus                 fb_ddr_arb_if.slave: requester and DDRAM signals
//   stat_drop           (FB_DDR_ARB_STATS_EN) saturating dropped-write count
//   stat_peak           (FB_DDR_ARB_STATS_EN) highest FIFO level seen
// Optional feature macro: FB_DDR_ARB_STATS_EN.
// -----------------------------------------------------------------------------
module fb_ddr_arb
  import fb_ddr_pkg::*;
#(
  parameter int FIFO_AW = 4,
  parameter int HIWAT   = 8
) (
  input  logic             clk_video,
  input  logic             rst,
  fb_ddr_arb_if.slave      bus
`ifdef FB_DDR_ARB_STATS_EN
  ,
  output logic [15:0]      stat_drop,
  output logic [FIFO_AW:0] stat_peak
`endif
);

  localparam logic [FIFO_AW:0] L_HIWAT = (FIFO_AW+1)'(HIWAT);

  wr_entry_t          w_push_data;
  wr_entry_t          w_head;
  logic [FIFO_AW:0]   w_level;
  logic               w_empty;
  logic               w_drop;
  logic               w_pop;

  state_t             r_state, w_state_nxt;
  logic               r_we, w_we_nxt;
  logic               r_rd, w_rd_nxt;
  logic [DDR_AW-1:0]  r_addr, w_addr_nxt;
  logic [DDR_DW-1:0]  r_din, w_din_nxt;
  logic [DDR_BEW-1:0] r_be, w_be_nxt;
  logic [7:0]         r_bcnt, w_bcnt_nxt;
  logic               r_ack, w_ack_nxt;
  logic               r_dv, w_dv_nxt;
  logic [DDR_DW-1:0]  r_dout, w_dout_nxt;
  logic               r_done, w_done_nxt;
  logic [7:0]         r_cnt, w_cnt_nxt;
  logic               r_ovf;
  logic               w_go_rd;
  logic               w_go_wr;

  assign w_push_data = '{addr: bus.wr_addr, din: bus.wr_din, be: bus.wr_be};

  fb_ddr_wfifo #(.AW(FIFO_AW)) u_wfifo (
    .clk_video   (clk_video),
    .rst         (rst),
    .i_push_req  (bus.wr_req),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_level     (w_level),
    .o_empty     (w_empty),
    .o_drop      (w_drop)
  );

  // IDLE arbitration: a pending read goes first unless writes have backed up
  // to HIWAT; otherwise drain writes; an idle FIFO lets any read through.
  always_comb begin
    w_go_rd = 1'b0;
    w_go_wr = 1'b0;
    if (r_state == ST_IDLE) begin
      if (bus.rd_req && (w_level < L_HIWAT)) w_go_rd = 1'b1;
      else if (!w_empty)                     w_go_wr = 1'b1;
      else if (bus.rd_req)                   w_go_rd = 1'b1;
    end
  end

  // Next-state and next-output logic. Outputs are computed for the state
  // being entered so that the registered copies line up with r_state.
  // NOTE: every signal gets a default before the case; a path that leaves one
  // unassigned would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_we_nxt    = 1'b0;
    w_rd_nxt    = 1'b0;
    w_addr_nxt  = r_addr;
    w_din_nxt   = r_din;
    w_be_nxt    = r_be;
    w_bcnt_nxt  = r_bcnt;
    w_ack_nxt   = 1'b0;
    w_dv_nxt    = 1'b0;
    w_dout_nxt  = r_dout;
    w_done_nxt  = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_go_rd) begin
          w_state_nxt = ST_RD_CMD;
          w_rd_nxt    = 1'b1;
          w_addr_nxt  = bus.rd_addr;
          w_bcnt_nxt  = burst_len(bus.rd_len);
        end else if (w_go_wr) begin
          w_state_nxt = ST_WR;
          w_we_nxt    = 1'b1;
          w_addr_nxt  = w_head.addr;
          w_din_nxt   = w_head.din;
          w_be_nxt    = w_head.be;
          w_bcnt_nxt  = 8'd1;
        end
      end
      ST_WR: begin
        if (!bus.DDRAM_BUSY) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_we_nxt    = 1'b1;
        end
      end
      ST_RD_CMD: begin
        if (!bus.DDRAM_BUSY) begin
          w_ack_nxt   = 1'b1;
          w_cnt_nxt   = r_bcnt;
          w_state_nxt = ST_RD_DATA;
        end else begin
          w_rd_nxt    = 1'b1;
        end
      end
      ST_RD_DATA: begin
        if (bus.DDRAM_DOUT_READY) begin
          w_dv_nxt   = 1'b1;
          w_dout_nxt = bus.DDRAM_DOUT;
          w_cnt_nxt  = r_cnt - 8'd1;
          if (r_cnt == 8'd1) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_video) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_we    <= 1'b0;
      r_rd    <= 1'b0;
      r_addr  <= '0;
      r_din   <= '0;
      r_be    <= '0;
      r_bcnt  <= '0;
      r_ack   <= 1'b0;
      r_dv    <= 1'b0;
      r_dout  <= '0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_we    <= w_we_nxt;
      r_rd    <= w_rd_nxt;
      r_addr  <= w_addr_nxt;
      r_din   <= w_din_nxt;
      r_be    <= w_be_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_ack   <= w_ack_nxt;
      r_dv    <= w_dv_nxt;
      r_dout  <= w_dout_nxt;
      r_done  <= w_done_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ovf   <= r_ovf | w_drop;
    end
  end

  assign bus.DDRAM_WE       = r_we;
  assign bus.DDRAM_RD       = r_rd;
  assign bus.DDRAM_ADDR     = r_addr;
  assign bus.DDRAM_DIN      = r_din;
  assign bus.DDRAM_BE       = r_be;
  assign bus.DDRAM_BURSTCNT = r_bcnt;
  assign bus.rd_ack         = r_ack;
  assign bus.rd_dv          = r_dv;
  assign bus.rd_dout        = r_dout;
  assign bus.rd_done        = r_done;
  assign bus.wr_ovf         = r_ovf;

`ifdef FB_DDR_ARB_STATS_EN
  logic [15:0]      r_stat_drop;
  logic [FIFO_AW:0] r_stat_peak;

  always_ff @(posedge clk_video) begin
    if (rst) begin
      r_stat_drop <= '0;
      r_stat_peak <= '0;
    end else begin
      if (w_drop && (r_stat_drop != 16'hFFFF)) r_stat_drop <= r_stat_drop + 16'd1;
      if (w_level > r_stat_peak)               r_stat_peak <= w_level;
    end
  end

  assign stat_drop = r_stat_drop;
  assign stat_peak = r_stat_peak;
`endif

endmodule

// File: tb/tb_fb_ddr_arb.sv
`timescale 1ns/1ps
module tb_fb_ddr_arb;
  import fb_ddr_pkg::*;

  localparam int FIFO_AW = 4;
  localparam int HIWAT   = 8;
  localparam int DEPTH   = 16;

  logic clk_video = 1'b0;
  logic rst;
  always #5 clk_video = ~clk_video;

  fb_ddr_arb_if bus();

`ifdef FB_DDR_ARB_STATS_EN
  logic [15:0]      stat_drop;
  logic [FIFO_AW:0] stat_peak;
`endif

  fb_ddr_arb #(.FIFO_AW(FIFO_AW), .HIWAT(HIWAT)) dut (
    .clk_video (clk_video),
    .rst       (rst),
    .bus       (bus)
`ifdef FB_DDR_ARB_STATS_EN
    ,
    .stat_drop (stat_drop),
    .stat_peak (stat_peak)
`endif
  );

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } rd_beat_t;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int dv_cnt = 0;
  int ack_cnt = 0;

  wr_entry_t wq[$];
  rd_beat_t  rq[$];
  wr_entry_t mon_e;
  rd_beat_t  mon_b;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk_video) begin
    if (rst === 1'b0) begin
      if (bus.DDRAM_WE && !bus.DDRAM_BUSY) begin
        wr_cnt++;
        if (wq.size() == 0) begin
          check("wr_unexpected", bus.DDRAM_WE, 1'b0);
        end else begin
          mon_e = wq.pop_front();
          check("wr_addr", bus.DDRAM_ADDR, mon_e.addr);
          check("wr_din", bus.DDRAM_DIN, mon_e.din);
          check("wr_be", bus.DDRAM_BE, mon_e.be);
          check("wr_bcnt", bus.DDRAM_BURSTCNT, 8'd1);
        end
      end
      if (bus.rd_dv) begin
        dv_cnt++;
        if (rq.size() == 0) begin
          check("rd_dv_unexpected", bus.rd_dv, 1'b0);
        end else begin
          mon_b = rq.pop_front();
          check("rd_dout", bus.rd_dout, mon_b.data);
          check("rd_done_last", bus.rd_done, mon_b.last);
        end
      end else begin
        check("rd_done_stray", bus.rd_done, 1'b0);
      end
      if (bus.rd_ack) ack_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_video);
    #1;
  endtask

  task automatic push(input logic [28:0] a, input logic [63:0] d, input logic [7:0] b);
    bus.wr_req  = 1'b1;
    bus.wr_addr = a;
    bus.wr_din  = d;
    bus.wr_be   = b;
    if (wq.size() < DEPTH) wq.push_back('{addr: a, din: d, be: b});
    tick();
    bus.wr_req  = 1'b0;
  endtask

  task automatic beat(input logic [63:0] d, input logic counted, input logic last);
    bus.DDRAM_DOUT_READY = 1'b1;
    bus.DDRAM_DOUT       = d;
    if (counted) rq.push_back('{data: d, last: last});
    tick();
    bus.DDRAM_DOUT_READY = 1'b0;
  endtask

  task automatic wait_ack(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (bus.rd_ack) seen = 1'b1;
      else tick();
    end
    check(tag, seen, 1'b1);
  endtask

  task automatic wait_drain(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 120 && !done; i++) begin
      if (wq.size() == 0) done = 1'b1;
      else tick();
    end
    check(tag, done, 1'b1);
    tick(); tick(); tick();
  endtask

  task automatic wait_cmd(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (bus.DDRAM_RD || bus.DDRAM_WE) seen = 1'b1;
      else tick();
    end
  endtask

  int         wc;
  int         ac;
  int         dc;
  logic       seen;
  logic [7:0] pattern;
  int         k;

  initial begin
    rst                  = 1'b1;
    bus.wr_req           = 1'b0;
    bus.wr_addr          = '0;
    bus.wr_din           = '0;
    bus.wr_be            = '0;
    bus.rd_req           = 1'b0;
    bus.rd_addr          = '0;
    bus.rd_len           = '0;
    bus.DDRAM_BUSY       = 1'b0;
    bus.DDRAM_DOUT       = '0;
    bus.DDRAM_DOUT_READY = 1'b0;

    // Reset state
    tick(); tick(); tick();
    check("rst_we", bus.DDRAM_WE, 1'b0);
    check("rst_rd", bus.DDRAM_RD, 1'b0);
    check("rst_addr", bus.DDRAM_ADDR, 29'd0);
    check("rst_bcnt", bus.DDRAM_BURSTCNT, 8'd0);
    check("rst_ovf", bus.wr_ovf, 1'b0);
    check("rst_ack", bus.rd_ack, 1'b0);
    check("rst_dv", bus.rd_dv, 1'b0);
    check("rst_dout", bus.rd_dout, 64'd0);
    rst = 1'b0;
    tick();

    // Single write, BUSY=0: WE exactly one cycle, two cycles after the push
    push(29'h0000100, 64'hA5A5_A5A5_A5A5_A5A5, 8'h0F);
    check("t1_we_c1", bus.DDRAM_WE, 1'b0);
    tick();
    check("t1_we_c2", bus.DDRAM_WE, 1'b1);
    check("t1_addr", bus.DDRAM_ADDR, 29'h0000100);
    check("t1_din", bus.DDRAM_DIN, 64'hA5A5_A5A5_A5A5_A5A5);
    check("t1_be", bus.DDRAM_BE, 8'h0F);
    check("t1_bcnt", bus.DDRAM_BURSTCNT, 8'd1);
    tick();
    check("t1_we_c3", bus.DDRAM_WE, 1'b0);
    tick(); tick();

    // BUSY hold: command and fields stable for 5 BUSY cycles, pop on the 6th
    bus.DDRAM_BUSY = 1'b1;
    push(29'h0000200, 64'h0123_4567_89AB_CDEF, 8'hF0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t2_we_hold", bus.DDRAM_WE, 1'b1);
      check("t2_addr_hold", bus.DDRAM_ADDR, 29'h0000200);
      check("t2_din_hold", bus.DDRAM_DIN, 64'h0123_4567_89AB_CDEF);
      tick();
    end
    bus.DDRAM_BUSY = 1'b0;
    check("t2_we_6th", bus.DDRAM_WE, 1'b1);
    check("t2_level_before", dut.w_level, 5'd1);
    tick();
    check("t2_we_after", bus.DDRAM_WE, 1'b0);
    check("t2_level_after", dut.w_level, 5'd0);
    tick();

    // Read burst of 4 with non-contiguous DOUT_READY
    ac = ack_cnt;
    dc = dv_cnt;
    bus.rd_req  = 1'b1;
    bus.rd_addr = 29'h0001000;
    bus.rd_len  = 8'd4;
    tick();
    check("t3_rd_cmd", bus.DDRAM_RD, 1'b1);
    check("t3_rd_addr", bus.DDRAM_ADDR, 29'h0001000);
    check("t3_rd_bcnt", bus.DDRAM_BURSTCNT, 8'd4);
    tick();
    check("t3_ack", bus.rd_ack, 1'b1);
    check("t3_rd_dropped", bus.DDRAM_RD, 1'b0);
    bus.rd_req = 1'b0;
    pattern = 8'b0100_1101;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (pattern[i]) begin
        beat(64'hD000_0000_0000_0000 | 64'(k * 3 + 1), 1'b1, (k == 3));
        k++;
      end else begin
        tick();
      end
    end
    tick();
    // Stray beat while idle must be ignored
    beat(64'hBAD0_BAD0_BAD0_BAD0, 1'b0, 1'b0);
    check("t3_stray_dv", bus.rd_dv, 1'b0);
    tick();
    check("t3_ack_count", ack_cnt - ac, 1);
    check("t3_dv_count", dv_cnt - dc, 4);
    check("t3_rq_empty", rq.size(), 0);

    // Priority at level 3: pending read goes before queued writes
    bus.rd_req  = 1'b1;
    bus.rd_addr = 29'h0002000;
    bus.rd_len  = 8'd0;
    wait_ack("p3_ack1");
    bus.rd_addr = 29'h0003000;
    bus.rd_len  = 8'd2;
    push(29'h0000301, 64'h3001, 8'h01);
    push(29'h0000302, 64'h3002, 8'h02);
    push(29'h0000303, 64'h3003, 8'h03);
    beat(64'h2222_0000_0000_0001, 1'b1, 1'b1);
    wait_cmd(seen);
    check("p3_cmd_seen", seen, 1'b1);
    check("p3_first_is_rd", bus.DDRAM_RD, 1'b1);
    check("p3_first_not_we", bus.DDRAM_WE, 1'b0);
    check("p3_rd_addr", bus.DDRAM_ADDR, 29'h0003000);
    check("p3_level", dut.w_level, 5'd3);
    wait_ack("p3_ack2");
    bus.rd_req = 1'b0;
    beat(64'h3333_0000_0000_0001, 1'b1, 1'b0);
    beat(64'h3333_0000_0000_0002, 1'b1, 1'b1);
    wait_drain("p3_drain");
    check("p3_level_end", dut.w_level, 5'd0);

    // Priority at level 8 (HIWAT): one write drains to level 7, then the read
    bus.rd_req  = 1'b1;
    bus.rd_addr = 29'h0004000;
    bus.rd_len  = 8'd1;
    wait_ack("p8_ack1");
    bus.rd_addr = 29'h0005000;
    for (int i = 0; i < 8; i++) push(29'h0000800 + 29'(i), 64'h8800 + 64'(i), 8'hFF);
    beat(64'h4444_0000_0000_0001, 1'b1, 1'b1);
    wc = wr_cnt;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (bus.DDRAM_RD) seen = 1'b1;
      else tick();
    end
    check("p8_rd_seen", seen, 1'b1);
    check("p8_writes_before_rd", wr_cnt - wc, 1);
    check("p8_level_at_rd", dut.w_level, 5'd7);
    check("p8_rd_addr", bus.DDRAM_ADDR, 29'h0005000);
    wait_ack("p8_ack2");
    bus.rd_req = 1'b0;
    beat(64'h5555_0000_0000_0001, 1'b1, 1'b1);
    wait_drain("p8_drain");
    check("p8_level_end", dut.w_level, 5'd0);

    // Overflow: 20 pushes with BUSY=1
    bus.DDRAM_BUSY = 1'b1;
    for (int i = 0; i < 20; i++) push(29'h0006000 + 29'(i), {32'hC0DE_0000, 32'(i)}, 8'(i + 1));
    tick();
    check("ovf_level", dut.w_level, 5'd16);
    check("ovf_flag", bus.wr_ovf, 1'b1);
`ifdef FB_DDR_ARB_STATS_EN
    check("ovf_stat_drop", stat_drop, 16'd4);
    check("ovf_stat_peak", stat_peak, 5'd16);
`endif
    wc = wr_cnt;
    bus.DDRAM_BUSY = 1'b0;
    wait_drain("ovf_drain");
    check("ovf_drain_count", wr_cnt - wc, 16);
    check("ovf_level_end", dut.w_level, 5'd0);
    check("ovf_flag_sticky", bus.wr_ovf, 1'b1);

    // Reset mid-burst after 2 of 4 beats
    ac = ack_cnt;
    bus.rd_req  = 1'b1;
    bus.rd_addr = 29'h0007000;
    bus.rd_len  = 8'd4;
    wait_ack("rb_ack");
    bus.rd_req = 1'b0;
    beat(64'h7777_0000_0000_0001, 1'b1, 1'b0);
    beat(64'h7777_0000_0000_0002, 1'b1, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    check("rb_dv", bus.rd_dv, 1'b0);
    check("rb_done", bus.rd_done, 1'b0);
    check("rb_ack0", bus.rd_ack, 1'b0);
    check("rb_ovf_cleared", bus.wr_ovf, 1'b0);
    check("rb_rd", bus.DDRAM_RD, 1'b0);
    check("rb_addr", bus.DDRAM_ADDR, 29'd0);
    check("rb_dout", bus.rd_dout, 64'd0);
`ifdef FB_DDR_ARB_STATS_EN
    check("rb_stat_drop", stat_drop, 16'd0);
`endif
    rst = 1'b0;
    beat(64'h7777_0000_0000_0003, 1'b0, 1'b0);
    check("rb_ignored_dv1", bus.rd_dv, 1'b0);
    beat(64'h7777_0000_0000_0004, 1'b0, 1'b0);
    check("rb_ignored_dv2", bus.rd_dv, 1'b0);
    check("rb_no_done", bus.rd_done, 1'b0);
    tick(); tick();
    check("rb_rq_empty", rq.size(), 0);
    check("rb_ack_once", ack_cnt - ac, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
